dot_product_accumulator: RTL and testbench
==========================================

// Module: dot_product_accumulator
// PURPOSE
//   Consumes the signed product stream of the 11-bit serial multiplier (its valid/S outputs).
//   Sums every K consecutive products into one dot-product term of a GEMV row.
//   Presents each finished sum through a one-entry valid/ready output buffer, tagged with a row index.
//   Exerts backpressure on the operand issuer through in_ready.
// PARAMETERS
//   PW    22              product width (2 x multiplier operand width), signed
//   K     8               products per dot product, >=2
//   ROWS  4               rows per matrix pass; row tag wraps at ROWS, >=1
//   AW    PW+$clog2(K)    accumulator/output width, signed (derived, not overridden)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        product strobe (multiplier valid), one cycle per product
//   in_prod    in   PW       signed product (multiplier S)
//   in_ready   out  1        product can be accepted this cycle
//   flush      in   1        synchronous abort of the partial dot product
//   out_valid  out  1        out_sum/out_row/out_last hold a finished result
//   out_ready  in   1        consumer takes the result this cycle
//   out_sum    out  AW       signed dot product
//   out_row    out  $clog2(ROWS)+1  row index of out_sum
//   out_last   out  1        out_row == ROWS-1
//   busy       out  1        partial sum in progress (cnt != 0)
// BEHAVIOUR
//   - Reset (async assert, sync-safe release) clears acc, cnt, row, out_sum, out_row, out_last, out_valid and busy to 0.
//   - Reset mid-sum discards the partial sum and any pending output.
//   - Accept = in_valid & in_ready.
//     - Products are sign-extended PW->AW.
//     - Accumulation is never saturated; AW guarantees no overflow.
//   - State is the term counter cnt (0..K-1) plus out_valid. Transitions on accept:
//     - cnt==0: acc <= prod; cnt <= 1.
//     - 0<cnt<K-1: acc <= acc+prod; cnt <= cnt+1.
//     - cnt==K-1: out_sum <= acc+prod; out_row <= row; out_last <= (row==ROWS-1); out_valid <= 1; cnt <= 0.
//       row <= row==ROWS-1 ? 0 : row+1.
//   - Latency: out_valid rises the cycle after the K-th product is accepted.
//   - in_ready = !(cnt==K-1 & out_valid & !out_ready).
//     - Only the final term stalls; earlier terms are accepted while the buffer is full.
//     - If in_valid is high while in_ready is low, the product is dropped.
//     - The issuer must not pulse en while in_ready is low; the multiplier cannot stall.
//   - Output handshake:
//     - out_valid & out_ready clears out_valid next cycle unless a new result loads in the same cycle.
//     - Same-cycle drain + K-th product: the new result replaces the old one; out_valid stays 1 with no bubble.
//     - out_sum/out_row/out_last are held stable while out_valid & !out_ready.
//   - flush is sampled each cycle and has priority over accept:
//     - cnt <= 0 and acc <= 0; the product in the same cycle is discarded.
//     - row, the output buffer and out_valid are unaffected.
//   - busy = (cnt != 0), registered view of the partial state.
// TESTING (K=4, ROWS=2 unless stated)
//   1. Products 5,-3,7,-1 with out_ready=1 -> one cycle after the 4th: out_valid=1, out_sum=8, out_row=0, out_last=0.
//   2. K=8, eight products of (-1024)*(-1024)=1048576 -> out_sum=8388608.
//      Then eight products of (-1024)*1023 -> out_sum=-8380416, with no wrap.
//   3. out_ready=0, second dot product 1,1,1 accepted then 4th pending -> in_ready=0; out_sum stays 8.
//      Raise out_ready -> 8 is taken, the 4th product is accepted next cycle, and out_sum=4 appears.
//   4. Drain and K-th accept in the same cycle -> out_valid stays high, out_sum updates directly.
//      The old value is counted once by the consumer.
//   5. Products 9,9 then flush, then 1,2,3,4 -> out_sum=10; the flush cycle product is ignored.
//      Row tags run 0,1,0 with out_last=0,1,0 across three results.
//   6. Assert rst with cnt=2 and out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
//      After release, 2,2,2,2 -> out_sum=8, out_row=0.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Purpose: sums every K signed products into one GEMV dot-product term, tagged with a wrapping row index.
// Latency: out_valid rises one cycle after the K-th product is accepted.
// Backpressure: only the K-th term stalls (in_ready low) while the one-entry output buffer is full and not draining.
module dot_product_accumulator #(
   parameter int PW   = 22,
   parameter int K    = 8,
   parameter int ROWS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic signed [PW-1:0]          in_prod,
   output logic                          in_ready,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [PW+$clog2(K)-1:0] out_sum,
   output logic [$clog2(ROWS):0]         out_row,
   output logic                          out_last,
   output logic                          busy
);

   localparam int AW = PW + $clog2(K);
   localparam int CW = $clog2(K);
   localparam int RW = $clog2(ROWS) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   logic signed [AW-1:0] acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [RW-1:0]        row_q, row_d;
   logic signed [AW-1:0] out_sum_q, out_sum_d;
   logic [RW-1:0]        out_row_q, out_row_d;
   logic                 out_last_q, out_last_d;
   logic                 out_valid_q, out_valid_d;

   logic signed [AW-1:0] prod_ext;
   logic                 accept;

   // Widen the product with its sign bit; AW leaves headroom for K terms, so the sum never wraps.
   assign prod_ext = {{(AW - PW){in_prod[PW-1]}}, in_prod};

   // The final term may only land if the buffer is empty or being drained in this same cycle.
   assign in_ready = !((cnt_q == CNT_LAST) && out_valid_q && !out_ready);
   assign accept   = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_row   = out_row_q;
   assign out_last  = out_last_q;
   assign busy      = (cnt_q != '0);

   // Next-state: drain the buffer, then apply flush (which wins) or the accepted product.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      out_sum_d   = out_sum_q;
      out_row_d   = out_row_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (flush) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (cnt_q == '0) begin
            acc_d = prod_ext;
            cnt_d = CNT_ONE;
         end else if (cnt_q != CNT_LAST) begin
            acc_d = acc_q + prod_ext;
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            // A load in the same cycle as a drain replaces the old result with no bubble.
            out_sum_d   = acc_q + prod_ext;
            out_row_d   = row_q;
            out_last_d  = (row_q == ROW_LAST);
            out_valid_d = 1'b1;
            cnt_d       = '0;
            row_d       = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
         end
      end
   end

   // State registers; reset throws away any partial sum and pending result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         row_q       <= '0;
         out_sum_q   <= '0;
         out_row_q   <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         out_sum_q   <= out_sum_d;
         out_row_q   <= out_row_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: a K=4/ROWS=2 instance driven by directed and random
// products, and a K=8/ROWS=4 instance for the full-range sums; results checked from queues.
module tb_dot_product_accumulator;

   localparam int PW  = 22;
   localparam int KA  = 4;
   localparam int RA  = 2;
   localparam int AWA = PW + 2;
   localparam int RWA = 2;
   localparam int KB  = 8;
   localparam int RB  = 4;
   localparam int AWB = PW + 3;
   localparam int RWB = 3;

   typedef struct {
      longint sum;
      int     row;
      bit     last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                  a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_last, a_busy;
   logic signed [PW-1:0]  a_in_prod;
   logic signed [AWA-1:0] a_out_sum;
   logic [RWA-1:0]        a_out_row;

   logic                  b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_last, b_busy;
   logic signed [PW-1:0]  b_in_prod;
   logic signed [AWB-1:0] b_out_sum;
   logic [RWB-1:0]        b_out_row;

   dot_product_accumulator #(.PW(PW), .K(KA), .ROWS(RA)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_prod(a_in_prod), .in_ready(a_in_ready),
      .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
      .out_row(a_out_row), .out_last(a_out_last), .busy(a_busy)
   );

   dot_product_accumulator #(.PW(PW), .K(KB), .ROWS(RB)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_prod(b_in_prod), .in_ready(b_in_ready),
      .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
      .out_row(b_out_row), .out_last(b_out_last), .busy(b_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of instance A: terms of the open dot product, buffer occupancy, row tag.
   longint terms[$];
   bit     obuf;
   int     row;
   exp_t   sb[$];
   exp_t   sbb[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle on instance A: drive, check handshake state against the model, advance the model.
   task automatic step(input bit v, input longint p, input bit fl, input bit ordy);
      bit     rdy;
      bit     load;
      longint s;
      exp_t   e;
      a_in_valid  = v;
      a_in_prod   = PW'(p);
      a_flush     = fl;
      a_out_ready = ordy;
      #1;
      rdy = !((terms.size() == KA - 1) && obuf && !ordy);
      chk("a_in_ready", longint'(a_in_ready), longint'(rdy));
      chk("a_out_valid", longint'(a_out_valid), longint'(obuf));
      chk("a_busy", longint'(a_busy), longint'(terms.size() != 0));
      load = 1'b0;
      if (fl) begin
         terms.delete();
      end else if (v && rdy) begin
         terms.push_back(longint'(a_in_prod));
         if (terms.size() == KA) begin
            s = 0;
            foreach (terms[i]) s += terms[i];
            e.sum  = s;
            e.row  = row;
            e.last = (row == RA - 1);
            sb.push_back(e);
            terms.delete();
            row  = (row + 1) % RA;
            load = 1'b1;
         end
      end
      if (load) obuf = 1'b1;
      else if (obuf && ordy) obuf = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic sum4(input longint p0, input longint p1, input longint p2, input longint p3, input bit ordy);
      step(1'b1, p0, 1'b0, ordy);
      step(1'b1, p1, 1'b0, ordy);
      step(1'b1, p2, 1'b0, ordy);
      step(1'b1, p3, 1'b0, ordy);
   endtask

   // Monitor A: whatever the DUT presents must be the oldest unconsumed result; a taken result is retired.
   always @(negedge clk) begin
      if (!rst && a_out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected: out_valid=1 out_sum=%0d, expected no pending result", a_out_sum);
         end else begin
            chk("a_out_sum", longint'(a_out_sum), sb[0].sum);
            chk("a_out_row", longint'(a_out_row), longint'(sb[0].row));
            chk("a_out_last", longint'(a_out_last), longint'(sb[0].last));
            if (a_out_ready) void'(sb.pop_front());
         end
      end
   end

   // Monitor B: same contract for the wide instance.
   always @(negedge clk) begin
      if (!rst && b_out_valid) begin
         if (sbb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_unexpected: out_valid=1 out_sum=%0d, expected no pending result", b_out_sum);
         end else begin
            chk("b_out_sum", longint'(b_out_sum), sbb[0].sum);
            chk("b_out_row", longint'(b_out_row), longint'(sbb[0].row));
            chk("b_out_last", longint'(b_out_last), longint'(sbb[0].last));
            if (b_out_ready) void'(sbb.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint               bsum;
      longint               bp;
      exp_t                 e;
      logic signed [PW-1:0] r;
      longint               p;

      rst = 1'b0;
      a_in_valid = 1'b0; a_in_prod = '0; a_flush = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_prod = '0; b_flush = 1'b0; b_out_ready = 1'b1;
      terms.delete(); obuf = 1'b0; row = 0;
      #1 rst = 1'b1;
      #1;
      chk("rst_a_out_valid", longint'(a_out_valid), 0);
      chk("rst_a_out_sum", longint'(a_out_sum), 0);
      chk("rst_a_out_row", longint'(a_out_row), 0);
      chk("rst_a_out_last", longint'(a_out_last), 0);
      chk("rst_a_busy", longint'(a_busy), 0);
      chk("rst_b_out_valid", longint'(b_out_valid), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // K=8: full-magnitude positive products, then mixed-sign ones, with no wrap.
      for (int d = 0; d < 2; d++) begin
         bp   = (d == 0) ? (-1024) * (-1024) : (-1024) * 1023;
         bsum = 0;
         for (int i = 0; i < KB; i++) begin
            b_in_valid = 1'b1;
            b_in_prod  = PW'(bp);
            bsum += bp;
            #1;
            chk("b_in_ready", longint'(b_in_ready), 1);
            if (i == KB - 1) begin
               e.sum = bsum; e.row = d; e.last = 1'b0;
               sbb.push_back(e);
            end
            @(posedge clk);
            #1;
         end
      end
      b_in_valid = 1'b0;
      chk("b_sum_pos_const", 8 * ((-1024) * (-1024)), 8388608);
      repeat (3) begin @(posedge clk); #1; end

      // Basic dot product: 5,-3,7,-1 -> 8, row 0.
      sum4(5, -3, 7, -1, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // Buffer full: earlier terms accepted, final term stalls until the drain.
      sum4(2, 2, 2, 2, 1'b0);
      step(1'b1, 1, 1'b0, 1'b0);
      step(1'b1, 1, 1'b0, 1'b0);
      step(1'b1, 1, 1'b0, 1'b0);
      step(1'b1, 9, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);

      // Drain and final term in the same cycle: result replaced with no bubble.
      step(1'b1, 3, 1'b0, 1'b0);
      step(1'b1, 3, 1'b0, 1'b0);
      step(1'b1, 3, 1'b0, 1'b0);
      step(1'b1, 5, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // Flush discards 9,9 and its own cycle's product; row tags keep running.
      step(1'b1, 9, 1'b0, 1'b1);
      step(1'b1, 9, 1'b0, 1'b1);
      step(1'b1, 100, 1'b1, 1'b1);
      sum4(1, 2, 3, 4, 1'b1);
      sum4(1, 1, 1, 1, 1'b1);
      sum4(0, 0, 0, 0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // Asynchronous reset with a partial sum and a pending result.
      sum4(2, 2, 2, 2, 1'b0);
      step(1'b1, 3, 1'b0, 1'b0);
      step(1'b1, 3, 1'b0, 1'b0);
      a_in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", longint'(a_out_valid), 0);
      chk("arst_out_sum", longint'(a_out_sum), 0);
      chk("arst_out_row", longint'(a_out_row), 0);
      chk("arst_out_last", longint'(a_out_last), 0);
      chk("arst_busy", longint'(a_busy), 0);
      terms.delete(); obuf = 1'b0; row = 0; sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      sum4(2, 2, 2, 2, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // Random traffic, including extreme products, dropped strobes and flushes.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 7))
            0:       p = -(longint'(1) << (PW - 1));
            1:       p = (longint'(1) << (PW - 1)) - 1;
            default: begin r = PW'($urandom); p = longint'(r); end
         endcase
         step($urandom_range(0, 3) != 0, p, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      end
      repeat (3) step(1'b0, 0, 1'b0, 1'b1);

      chk("a_results_all_seen", longint'(sb.size()), 0);
      chk("b_results_all_seen", longint'(sbb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
